// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit frame generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP,
        BREAK
    } state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Bit times occupied by one frame, including stop and idle-gap bits.
    function automatic int unsigned frame_bits(input int unsigned data_w,
                                               input int unsigned parity_mode,
                                               input int unsigned stop_bits,
                                               input int unsigned gap_bits);
        return 32'd1 + data_w + ((parity_mode != PAR_NONE) ? 32'd1 : 32'd0)
               + stop_bits + gap_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty and a dropped-write pulse.
module uart_tx_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic         overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_next;
    logic             rd_ok_c;
    logic             wr_ok_c;

    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign rd_ok_c = rd_en && !empty;
    assign wr_ok_c = wr_en && (!full || rd_ok_c);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        cnt_next = count;
        if (wr_ok_c && !rd_ok_c) begin
            cnt_next = CNT_W'(count + 1'b1);
        end else if (!wr_ok_c && rd_ok_c) begin
            cnt_next = CNT_W'(count - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_ok_c) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            if (rd_ok_c) rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            count    <= cnt_next;
            full     <= (cnt_next == CNT_W'(DEPTH));
            empty    <= (cnt_next == '0);
            overflow <= wr_en && full && !rd_ok_c;
        end
    end

endmodule

// File: rtl/uart_frame_gen.sv
// UART transmit frame generator: FIFO-fed start/data/parity/stop/gap serialiser.
// Define UART_FRAME_GEN_BREAK_EN to add the brk input and the line-break state.
module uart_frame_gen
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned GAP_BITS     = 0,
    parameter int unsigned FIFO_DEPTH   = 4
`ifdef UART_FRAME_GEN_BREAK_EN
    ,
    parameter int unsigned BREAK_BITS   = 12
`endif
) (
    input  logic              clk,
    input  logic              rst,
`ifdef UART_FRAME_GEN_BREAK_EN
    input  logic              brk,
`endif
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  shreg;
    logic               par_bit;
    logic [DATA_W-1:0]  rd_data;
    logic               bit_end_c;
    logic               finish_c;
    logic               start_c;
    logic               brk_req_c;

    uart_tx_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (start_c),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

`ifdef UART_FRAME_GEN_BREAK_EN
    logic brk_pend;
    assign brk_req_c = brk || brk_pend;
`else
    assign brk_req_c = 1'b0;
`endif

    assign bit_end_c = (bit_cnt == CNT_LAST);

    // Last bit time of the frame, whether it ends in a stop bit or a gap bit.
    assign finish_c = bit_end_c &&
                      (((state == STOP) && (idx == IDX_W'(STOP_BITS - 1)) && (GAP_BITS == 0)) ||
                       ((state == GAP)  && (idx == IDX_W'(GAP_BITS - 1))));

    // Pending break wins over queued data; a finishing frame chains straight into the next.
    assign start_c = !empty && !brk_req_c && ((state == IDLE) || finish_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            bit_cnt    <= '0;
            idx        <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
`ifdef UART_FRAME_GEN_BREAK_EN
            brk_pend   <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            bit_cnt    <= bit_end_c ? '0 : CNT_W'(bit_cnt + 1'b1);
`ifdef UART_FRAME_GEN_BREAK_EN
            if ((state == IDLE) && brk_req_c) begin
                brk_pend <= 1'b0;
            end else if (brk) begin
                brk_pend <= 1'b1;
            end
`endif
            if (start_c) begin
                state      <= START;
                tx         <= 1'b0;
                busy       <= 1'b1;
                bit_cnt    <= '0;
                idx        <= '0;
                shreg      <= rd_data;
                par_bit    <= (PARITY_MODE == PAR_ODD) ? ~(^rd_data) : ^rd_data;
                frame_done <= finish_c;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
`ifdef UART_FRAME_GEN_BREAK_EN
                        if (brk_req_c) begin
                            state <= BREAK;
                            tx    <= 1'b0;
                            busy  <= 1'b1;
                            idx   <= '0;
                        end
`endif
                    end
                    START: begin
                        if (bit_end_c) begin
                            state <= DATA;
                            tx    <= shreg[0];
                            shreg <= shreg >> 1;
                            idx   <= '0;
                        end
                    end
                    DATA: begin
                        if (bit_end_c) begin
                            if (idx == IDX_W'(DATA_W - 1)) begin
                                idx <= '0;
                                if (PARITY_MODE != PAR_NONE) begin
                                    state <= PARITY;
                                    tx    <= par_bit;
                                end else begin
                                    state <= STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                tx    <= shreg[0];
                                shreg <= shreg >> 1;
                                idx   <= IDX_W'(idx + 1'b1);
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end_c) begin
                            state <= STOP;
                            tx    <= 1'b1;
                            idx   <= '0;
                        end
                    end
                    STOP: begin
                        if (bit_end_c) begin
                            if (idx == IDX_W'(STOP_BITS - 1)) begin
                                idx <= '0;
                                if (GAP_BITS != 0) begin
                                    state <= GAP;
                                end else begin
                                    state      <= IDLE;
                                    busy       <= 1'b0;
                                    frame_done <= 1'b1;
                                end
                            end else begin
                                idx <= IDX_W'(idx + 1'b1);
                            end
                        end
                    end
                    GAP: begin
                        if (bit_end_c) begin
                            if (idx == IDX_W'(GAP_BITS - 1)) begin
                                idx        <= '0;
                                state      <= IDLE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                            end else begin
                                idx <= IDX_W'(idx + 1'b1);
                            end
                        end
                    end
`ifdef UART_FRAME_GEN_BREAK_EN
                    // Line held low for BREAK_BITS bit times, then one high bit time before IDLE.
                    BREAK: begin
                        if (bit_end_c) begin
                            if (idx == IDX_W'(BREAK_BITS)) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                idx   <= '0;
                            end else begin
                                if (idx == IDX_W'(BREAK_BITS - 1)) tx <= 1'b1;
                                idx <= IDX_W'(idx + 1'b1);
                            end
                        end
                    end
`endif
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_gen.sv
// Bench for uart_frame_gen: two configurations checked cycle by cycle against a frame-level schedule.
module tb_uart_frame_gen;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       a_rst, b_rst;
    logic       a_wr_en, b_wr_en;
    logic [7:0] a_wr_data, b_wr_data;
    logic       a_full, a_empty, a_ovf, a_tx, a_busy, a_done;
    logic       b_full, b_empty, b_ovf, b_tx, b_busy, b_done;
`ifdef UART_FRAME_GEN_BREAK_EN
    logic       a_brk = 1'b0;
    logic       b_brk = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    bit         sv[$];
    logic [7:0] sd[$];

    always #5 clk = ~clk;

    // Even parity, one stop bit, no gap.
    uart_frame_gen #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1),
        .GAP_BITS(0), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .clk(clk), .rst(a_rst),
`ifdef UART_FRAME_GEN_BREAK_EN
        .brk(a_brk),
`endif
        .wr_en(a_wr_en), .wr_data(a_wr_data), .full(a_full), .empty(a_empty),
        .overflow(a_ovf), .tx(a_tx), .busy(a_busy), .frame_done(a_done)
    );

    // Odd parity, two stop bits, one gap bit.
    uart_frame_gen #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(2),
        .GAP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .clk(clk), .rst(b_rst),
`ifdef UART_FRAME_GEN_BREAK_EN
        .brk(b_brk),
`endif
        .wr_en(b_wr_en), .wr_data(b_wr_data), .full(b_full), .empty(b_empty),
        .overflow(b_ovf), .tx(b_tx), .busy(b_busy), .frame_done(b_done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Line level for bit k of a frame carrying w: start, LSB-first data, parity, then all ones.
    function automatic logic frame_bit(input logic [7:0] w, input int k, input int mode);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(w[i]);
        if (k == 0) return 1'b0;
        if (k <= 8) return w[k-1];
        if (k == 9 && mode != 0) return (mode == 1) ? 1'(ones % 2) : 1'(1 - ones % 2);
        return 1'b1;
    endfunction

    task automatic drive(input bit sel, input bit v, input logic [7:0] d);
        if (sel) begin
            b_wr_en = v; b_wr_data = d;
        end else begin
            a_wr_en = v; a_wr_data = d;
        end
    endtask

    task automatic add(input bit v, input logic [7:0] d);
        sv.push_back(v);
        sd.push_back(d);
    endtask

    // Applies the writes in sv/sd on consecutive edges and checks every output after each edge.
    task automatic run_sched(input bit sel, input string nm);
        int         mode, stop, gap, flen, start_e, e, n;
        logic [7:0] q[$];
        logic [7:0] cur;
        bit         active, fin, ovf;
        logic       tx_e;
        logic       o_tx, o_busy, o_done, o_ovf, o_full, o_empty;
        mode = sel ? 2 : 1;
        stop = sel ? 2 : 1;
        gap  = sel ? 1 : 0;
        flen = (1 + 8 + ((mode != 0) ? 1 : 0) + stop + gap) * CPB;
        n = sv.size();
        active = 1'b0; start_e = 0; cur = 8'h00; e = 0;
        while (1) begin
            if (e < n) drive(sel, sv[e], sd[e]);
            else drive(sel, 1'b0, 8'h00);
            fin = active && (e == start_e + flen);
            if (fin) active = 1'b0;
            if (!active && q.size() > 0) begin
                cur = q.pop_front();
                active = 1'b1;
                start_e = e;
            end
            ovf = 1'b0;
            if (e < n && sv[e]) begin
                if (q.size() < DEPTH) q.push_back(sd[e]);
                else ovf = 1'b1;
            end
            tx_e = active ? frame_bit(cur, (e - start_e) / CPB, mode) : 1'b1;
            @(negedge clk);
            if (sel) begin
                o_tx = b_tx; o_busy = b_busy; o_done = b_done;
                o_ovf = b_ovf; o_full = b_full; o_empty = b_empty;
            end else begin
                o_tx = a_tx; o_busy = a_busy; o_done = a_done;
                o_ovf = a_ovf; o_full = a_full; o_empty = a_empty;
            end
            chk($sformatf("%s_tx@%0d", nm, e), o_tx, tx_e);
            chk($sformatf("%s_busy@%0d", nm, e), o_busy, active);
            chk($sformatf("%s_done@%0d", nm, e), o_done, fin);
            chk($sformatf("%s_ovf@%0d", nm, e), o_ovf, ovf);
            chk($sformatf("%s_full@%0d", nm, e), o_full, q.size() == DEPTH);
            chk($sformatf("%s_empty@%0d", nm, e), o_empty, q.size() == 0);
            e++;
            if (e >= n && !active && q.size() == 0) break;
        end
        drive(sel, 1'b0, 8'h00);
        sv.delete();
        sd.delete();
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_wr_en = 1'b0; b_wr_en = 1'b0;
        a_wr_data = 8'h00; b_wr_data = 8'h00;
        repeat (2) @(negedge clk);

        chk("rst_a_tx", a_tx, 1'b1);
        chk("rst_a_busy", a_busy, 1'b0);
        chk("rst_a_full", a_full, 1'b0);
        chk("rst_a_empty", a_empty, 1'b1);
        chk("rst_a_ovf", a_ovf, 1'b0);
        chk("rst_a_done", a_done, 1'b0);
        chk("rst_b_tx", b_tx, 1'b1);
        chk("rst_b_busy", b_busy, 1'b0);
        chk("rst_b_empty", b_empty, 1'b1);
        chk("rst_b_done", b_done, 1'b0);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        // Single even-parity frame.
        add(1'b1, 8'h0C);
        run_sched(1'b0, "a_0c");

        // Two words on consecutive cycles chain with no idle cycle.
        add(1'b1, 8'h0E);
        add(1'b1, 8'h03);
        run_sched(1'b0, "a_b2b");

        // Odd parity, two stop bits, one gap bit.
        add(1'b1, 8'hFF);
        run_sched(1'b1, "b_ff");

        // Six writes into a four-deep FIFO: one pop lets the fifth in, the sixth is dropped.
        for (int i = 0; i < 6; i++) add(1'b1, 8'($urandom));
        run_sched(1'b0, "a_ovf");

        // Random bursts with random holes on both configurations.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(3, 7));
            for (int i = 0; i < n; i++) add($urandom_range(0, 3) != 0, 8'($urandom));
            run_sched(r[0], $sformatf("rnd%0d", r));
        end

        // Reset in the middle of data bit 3 of 0x55.
        a_wr_en = 1'b1; a_wr_data = 8'h55;
        @(negedge clk);
        a_wr_en = 1'b0;
        repeat (18) @(negedge clk);
        chk("mid_tx_before_rst", a_tx, frame_bit(8'h55, 4, 1));
        chk("mid_busy_before_rst", a_busy, 1'b1);
        a_rst = 1'b1;
        #1;
        chk("mid_rst_tx", a_tx, 1'b1);
        chk("mid_rst_busy", a_busy, 1'b0);
        chk("mid_rst_empty", a_empty, 1'b1);
        @(negedge clk);
        a_rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_tx@%0d", c), a_tx, 1'b1);
            chk($sformatf("post_rst_done@%0d", c), a_done, 1'b0);
            chk($sformatf("post_rst_busy@%0d", c), a_busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_frame_gen.md
Name: uart_frame_gen

Overview:
Parametrised, synthesisable UART transmit frame generator with a small input FIFO.
- Replaces hand-timed serial stimulus: words are queued and serialised as start / data / optional parity / stop frames, with a programmable idle gap.
- Drives the rx pin of risc_v_top in benches; also usable as an on-chip UART TX.

Parameters:
DATA_W, 8, data bits per frame (5..9), LSB first
CLKS_PER_BIT, 5208, clock cycles per bit time (50 MHz / 9600 baud); minimum 2
PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)
GAP_BITS, 0, extra idle bit-times inserted after each frame's stop bits
FIFO_DEPTH, 4, input FIFO entries (power of two, >= 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
wr_en  input  1  push wr_data into FIFO
wr_data  input  DATA_W  word to transmit
full  output  1  FIFO full
empty  output  1  FIFO empty
overflow  output  1  one-cycle pulse: write dropped while full
tx  output  1  serial line, idle high, registered
busy  output  1  high from frame start through end of gap
frame_done  output  1  one-cycle pulse on the cycle after the last stop/gap bit ends

Behaviour:
- Reset values: tx=1, busy=0, full=0, empty=1, overflow=0, frame_done=0; FIFO pointers and count cleared; FSM=IDLE.
- Reset asserted mid-frame: tx returns high immediately; the queued data is lost.
- FSM states and transitions:
  - IDLE: when FIFO is not empty, pop into the shift register, set tx=0, go to START.
  - START: 1 bit time; then go to DATA with bit index 0.
  - DATA: DATA_W bit times, LSB first. Then go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: 1 bit time. Even mode sends the XOR of the data bits; odd mode sends its inverse.
  - STOP: STOP_BITS bit times with tx=1. Then go to GAP if GAP_BITS > 0, else finish.
  - GAP: GAP_BITS bit times with tx=1.
  - Finish: pulse frame_done and go to IDLE. If the FIFO is non-empty at that edge, pop the next word and drive tx=0 on the same edge, so back-to-back frames have no extra idle cycle.
- Bit timing:
  - The bit counter runs 0..CLKS_PER_BIT-1 and is sized $clog2(CLKS_PER_BIT).
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - Frame length is (1 + DATA_W + (PARITY_MODE != 0) + STOP_BITS + GAP_BITS) * CLKS_PER_BIT cycles.
- Latency: wr_en at edge N into an empty FIFO with the FSM in IDLE gives tx=0 after edge N+1.
- FIFO:
  - Write when full and no pop in the same cycle: data dropped, overflow pulses, state unchanged.
  - Write and pop in the same cycle: both take effect, including when full; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - full and empty are registered and derived from the count.
- busy is high in all states except IDLE.

Optional Feature:
Macro: UART_FRAME_GEN_BREAK_EN
- Defined:
  - Adds input port brk (1 bit) and parameter BREAK_BITS (default 12).
  - brk sampled high in IDLE enters state BREAK: tx=0 for BREAK_BITS bit times, then at least 1 bit time high, then IDLE.
  - busy is high throughout BREAK. No FIFO pop occurs and frame_done does not pulse.
  - brk raised mid-frame is held pending until the frame finishes.
- Undefined: no brk port, no BREAK state; the FSM and encoding are otherwise identical.

Decomposition:
- Package uart_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, GAP, BREAK
  - parity-mode constants: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
  - function frame_bits(DATA_W, PARITY_MODE, STOP_BITS, GAP_BITS)
- One sub-module: uart_tx_fifo, a synchronous FIFO parametrised by width and depth that provides full, empty and overflow.
- The FSM, bit timer and shift register live in the top module.

Test Plan:
- CLKS_PER_BIT=4, even parity, write 0x0C:
  - tx per 4-cycle bit = 0, 0,0,1,1,0,0,0,0, parity 0, 1.
  - frame_done pulses 44 cycles after tx falls.
- Even parity, write 0x0E, then 0x03 on the next cycle:
  - Parity bits 1 then 0.
  - Second start bit immediately follows the first stop bit; busy stays high for 88 cycles.
- PARITY_MODE=2, STOP_BITS=2, GAP_BITS=1, write 0xFF:
  - Parity bit = 1.
  - tx high for 12 cycles after parity.
  - Frame length 52 cycles.
- FIFO_DEPTH=4, write 6 words back-to-back while idle:
  - full rises after the 4th queued word; 5th accepted (one pop occurred); 6th triggers an overflow pulse.
  - Exactly 5 frames are sent, in order.
- Assert rst during DATA bit 3 of 0x55:
  - tx=1 and busy=0 immediately; empty=1.
  - No frame_done; after release, tx stays idle.
- With UART_FRAME_GEN_BREAK_EN, BREAK_BITS=12, pulse brk in IDLE:
  - tx low for 48 cycles then high ≥4 cycles.
  - A word queued during break starts only afterwards.
